// File: rtl/hwpe_tcdm_serializer.sv
// hwpe_tcdm_serializer
// Funnels N_PORTS TCDM master ports onto one downstream TCDM master port.
// A round-robin arbiter picks the request to forward. The index of each granted
// port is pushed into a small FIFO so that the in-order responses can be
// routed back to the port that issued them.
module hwpe_tcdm_serializer #(
  parameter int unsigned N_PORTS         = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  // upstream (accelerator side) ports
  input  logic [N_PORTS-1:0]               in_req_i,
  output logic [N_PORTS-1:0]               in_gnt_o,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]    in_add_i,
  input  logic [N_PORTS-1:0]               in_wen_i,
  input  logic [N_PORTS*BE_WIDTH-1:0]      in_be_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0]    in_wdata_i,
  output logic [DATA_WIDTH-1:0]            in_r_rdata_o,
  output logic [N_PORTS-1:0]               in_r_valid_o,
  // downstream (interconnect side) port
  output logic                             out_req_o,
  input  logic                             out_gnt_i,
  output logic [ADDR_WIDTH-1:0]            out_add_o,
  output logic                             out_wen_o,
  output logic [BE_WIDTH-1:0]              out_be_o,
  output logic [DATA_WIDTH-1:0]            out_wdata_o,
  input  logic [DATA_WIDTH-1:0]            out_r_rdata_i,
  input  logic                             out_r_valid_i,
  // status
  output logic                             busy_o,
  output logic                             err_o
);

  localparam int unsigned PORT_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned FIFO_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [FIFO_AW-1:0] LAST_SLOT  = FIFO_AW'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(MAX_OUTSTANDING);

  // Port index advanced by an offset, wrapping modulo N_PORTS (any N_PORTS).
  function automatic logic [PORT_W-1:0] port_add(input logic [PORT_W-1:0] base,
                                                  input int unsigned       off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_PORTS) sum = sum - N_PORTS;
    return PORT_W'(sum);
  endfunction

  // FIFO slot pointer advanced by one, wrapping modulo MAX_OUTSTANDING.
  function automatic logic [FIFO_AW-1:0] slot_next(input logic [FIFO_AW-1:0] ptr);
    return (ptr == LAST_SLOT) ? '0 : ptr + FIFO_AW'(1);
  endfunction

  // Registered state
  logic [PORT_W-1:0]  r_rr_ptr;
  logic [FIFO_AW-1:0] r_head;
  logic [FIFO_AW-1:0] r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;
  logic [PORT_W-1:0]  r_fifo [MAX_OUTSTANDING];

  // Combinational nets
  logic [PORT_W-1:0]  w_winner;
  logic               w_found;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_stray;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);

  // Round-robin search: first requesting port at or after r_rr_ptr, with wrap.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip the assignment infer a latch.
    w_winner = '0;
    w_found  = 1'b0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (!w_found && in_req_i[port_add(r_rr_ptr, k)]) begin
        w_winner = port_add(r_rr_ptr, k);
        w_found  = 1'b1;
      end
    end
  end

  // The request only looks at FIFO occupancy, never at out_gnt_i, and a pop
  // in the same cycle does not free a slot early (no full bypass).
  assign out_req_o = rst_ni & w_found & ~w_full;
  assign w_push    = out_req_o & out_gnt_i;
  assign w_pop     = rst_ni & out_r_valid_i & ~w_empty;
  assign w_stray   = out_r_valid_i & w_empty;

  // Forward the winner's request fields downstream; zero while in reset.
  always_comb begin
    out_add_o   = '0;
    out_wen_o   = 1'b0;
    out_be_o    = '0;
    out_wdata_o = '0;
    if (rst_ni) begin
      out_add_o   = in_add_i[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
      out_wen_o   = in_wen_i[w_winner];
      out_be_o    = in_be_i[w_winner*BE_WIDTH +: BE_WIDTH];
      out_wdata_o = in_wdata_i[w_winner*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Grant goes only to the winner; response valid goes to the oldest issuer.
  always_comb begin
    in_gnt_o           = '0;
    in_gnt_o[w_winner] = w_push;
    in_r_valid_o       = '0;
    if (w_pop) in_r_valid_o[r_fifo[r_head]] = 1'b1;
  end

  assign in_r_rdata_o = rst_ni ? out_r_rdata_i : '0;
  assign busy_o       = ~w_empty;
  assign err_o        = r_err;

  // Arbiter pointer, FIFO pointers/occupancy and sticky error flag.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      r_rr_ptr <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail   <= slot_next(r_tail);
        r_rr_ptr <= port_add(w_winner, 1);
      end
      if (w_pop) r_head <= slot_next(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_stray) r_err <= 1'b1;
    end
  end

  // Storage of issuing port indices, written on every handshake.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately not reset; entries are only read
    // when count says they are valid, so stale contents are harmless.
    if (w_push) r_fifo[r_tail] <= w_winner;
  end

endmodule

// File: doc/hwpe_tcdm_serializer.md
Name: hwpe_tcdm_serializer

Overview:
Downstream neighbour of the HWPE TCDM master ports. Funnels N_PORTS TCDM-style master ports from an accelerator onto a single TCDM master port into the SoC interconnect. Uses round-robin arbitration and routes in-order responses back to the issuing port through an outstanding-transaction FIFO.

Parameters:
N_PORTS, 4, number of upstream TCDM master ports (>=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
MAX_OUTSTANDING, 4, response-routing FIFO depth (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
in_req_i  in  N_PORTS  per-port request
in_gnt_o  out  N_PORTS  per-port grant
in_add_i  in  N_PORTS*ADDR_WIDTH  per-port address
in_wen_i  in  N_PORTS  per-port write enable, active low (1 = read)
in_be_i  in  N_PORTS*BE_WIDTH  per-port byte enable
in_wdata_i  in  N_PORTS*DATA_WIDTH  per-port write data
in_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all ports
in_r_valid_o  out  N_PORTS  per-port response valid
out_req_o  out  1  downstream request
out_gnt_i  in  1  downstream grant
out_add_o  out  ADDR_WIDTH  downstream address
out_wen_o  out  1  downstream wen
out_be_o  out  BE_WIDTH  downstream byte enable
out_wdata_o  out  DATA_WIDTH  downstream write data
out_r_rdata_i  in  DATA_WIDTH  downstream response data
out_r_valid_i  in  1  downstream response valid
busy_o  out  1  at least one transaction outstanding
err_o  out  1  sticky: response received with empty FIFO

Behaviour:
- State:
  - rr_ptr (log2 N_PORTS bits).
  - FIFO of port indices: MAX_OUTSTANDING entries, with head, tail and count.
  - err flag.
- Reset (rst_ni=0 at rising edge): rr_ptr=0, count=0, head=tail=0, err=0.
  - While rst_ni=0, out_req_o, in_gnt_o, in_r_valid_o are forced to 0.
  - Data outputs are don't-care; drive 0.
- Arbitration (combinational):
  - Winner = first port with in_req_i set, searching from rr_ptr upward with wrap.
  - out_req_o = (any in_req_i) & (count != MAX_OUTSTANDING).
  - out_add_o, out_wen_o, out_be_o, out_wdata_o = the winner's fields.
  - in_gnt_o[winner] = out_req_o & out_gnt_i. All other in_gnt_o bits are 0.
  - out_req_o must not depend on out_gnt_i.
- Handshake (out_req_o & out_gnt_i at clock edge):
  - Push winner index into the FIFO.
  - rr_ptr <= (winner+1) mod N_PORTS.
  - Without a handshake, rr_ptr holds. The winner may change between cycles while out_req_o is held; upstream ports keep their req until granted.
- Responses:
  - Downstream returns exactly one out_r_valid_i per granted transaction (read or write), in order, at least 1 cycle after grant.
  - On out_r_valid_i with count>0: in_r_valid_o[fifo[head]]=1 in the same cycle (0 latency). in_r_rdata_o = out_r_rdata_i. Pop the FIFO.
- Latency: request path and response path are both combinational, 0 cycles. Throughput is 1 transaction per cycle.
- Full: when count == MAX_OUTSTANDING, out_req_o=0 and no grant is issued, even if a pop occurs in the same cycle (no bypass). The request is issued the cycle after the pop.
- Simultaneous push and pop: count unchanged; head and tail both advance.
- Empty plus out_r_valid_i: no in_r_valid_o; count stays 0; err <= 1 (sticky until reset).
- Pointer wrap: head, tail and rr_ptr wrap modulo their ranges. Non-power-of-2 depths and port counts must be supported.
- busy_o = (count != 0). err_o = err.
- Reset mid-operation: outstanding entries are discarded. Responses arriving after reset release with an empty FIFO set err_o.

Test Plan:
- All 4 ports request reads at addrs 0x100/0x104/0x108/0x10C, out_gnt_i=1 always, responses 2 cycles later → grants in order 0,1,2,3 on consecutive cycles; in_r_valid_o one-hot per port in the same order with matching rdata; busy_o back to 0.
- Ports 1 and 3 request continuously, out_gnt_i=1 → grants alternate 1,3,1,3; neither port starves.
- MAX_OUTSTANDING=4, port 0 requests, out_gnt_i=1, no responses → exactly 4 grants, then out_req_o=0. One response → next grant the following cycle, not the same cycle.
- Grant and response in the same cycle at count=2 → count stays 2; response routed to the older port index.
- out_gnt_i=0 for 3 cycles with port 2 write (wen=0, be=4'b0011, wdata=0xDEADBEEF) → out_* stable for 3 cycles; in_gnt_o[2] only in the cycle out_gnt_i=1.
- out_r_valid_i with count=0 → no in_r_valid_o; err_o=1 until rst_ni=0 at an edge. Reset with 3 outstanding → busy_o=0 the next cycle.
